// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared FSM encoding and trigger-mode constants for the ADC capture buffer
package adc_cap_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_CAP  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;
    localparam logic [1:0] TRIG_EXT  = 2'b11;

endpackage

// File: rtl/adc_cap_ram.sv
// adc_cap_ram: simple dual-port sample RAM with registered read, block-RAM inferable
module adc_cap_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // write port and enabled registered read port; read data holds when re is low
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_buf.sv
// adc_capture_buf: triggered, decimated ADC burst capture into RAM with sequential CPU readout
module adc_capture_buf
    import adc_cap_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 9,
    parameter int DECW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   adc_data,
    input  logic            arm,
    input  logic [1:0]      trig_mode,
    input  logic [DW-1:0]   trig_level,
    input  logic            ext_trig,
    input  logic [DECW-1:0] decim,
    input  logic            rd_en,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     count
);

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    state_t          state_q, state_d;
    logic [DW-1:0]   s0_q, s1_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DECW-1:0] dcnt_q, dcnt_d;
    logic [AW:0]     count_q, count_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            rd_valid_q, rd_seen_q, rd_seen_d;
    logic            trig, we, pop;
    logic [DW-1:0]   ram_q;

    // next state: trigger detection, decimated writes, pops and re-arm
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dcnt_d   = dcnt_q;
        count_d  = count_q;
        we       = 1'b0;
        pop      = 1'b0;
        trig = (trig_mode == TRIG_IMM)  ? 1'b1 :
               (trig_mode == TRIG_RISE) ? (s1_q <  trig_level && s0_q >= trig_level) :
               (trig_mode == TRIG_FALL) ? (s1_q >= trig_level && s0_q <  trig_level) :
                                          ext_trig;
        case (state_q)
            S_IDLE: if (arm) begin
                state_d  = S_WAIT;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                dcnt_d   = '0;
            end
            S_WAIT, S_CAP: if (state_q == S_CAP || trig) begin
                state_d = S_CAP;
                dcnt_d  = (dcnt_q >= decim) ? '0 : dcnt_q + 1'b1;
                if (dcnt_q == '0) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == '1) begin
                        state_d = S_DONE;
                        count_d = FULL;
                    end
                end
            end
            S_DONE: if (arm) begin
                state_d  = S_WAIT;
                count_d  = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                dcnt_d   = '0;
            end else if (rd_en && count_q != '0) begin
                pop      = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
                if (count_q == (AW+1)'(1)) state_d = S_IDLE;
            end
        endcase
        busy_d    = (state_d == S_WAIT) || (state_d == S_CAP);
        done_d    = (state_d == S_DONE);
        rd_seen_d = rd_seen_q | pop;
    end

    // state registers, input pipe and registered status outputs
    always_ff @(posedge clk) begin
        s0_q <= adc_data;
        s1_q <= s0_q;
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dcnt_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dcnt_q     <= dcnt_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= pop;
            rd_seen_q  <= rd_seen_d;
        end
    end

    adc_cap_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (s0_q),
        .re    (pop),
        .raddr (rd_ptr_q),
        .rdata (ram_q)
    );

    // RAM output is unknown until the first pop after reset, so present zero until then
    assign rd_data  = rd_seen_q ? ram_q : '0;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_adc_capture_buf.sv
// tb_adc_capture_buf: scenario tasks with a sample scoreboard for adc_capture_buf
module tb_adc_capture_buf;

    localparam int N = 16;

    logic       clk = 1'b0, reset = 1'b1, arm = 1'b0, ext_trig = 1'b0, rd_en = 1'b0;
    logic [1:0] trig_mode = 2'b00;
    logic [7:0] trig_level = 8'h00, adc_data = 8'h00, decim = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done;
    logic [4:0] count;
    int         errors = 0, checks = 0;
    bit         ramp = 1'b0;
    logic [7:0] exp_q [$];

    adc_capture_buf #(.DW(8), .AW(4), .DECW(8)) dut (
        .clk(clk), .reset(reset), .adc_data(adc_data), .arm(arm), .trig_mode(trig_mode),
        .trig_level(trig_level), .ext_trig(ext_trig), .decim(decim), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task step();
        @(posedge clk);
        #1;
        if (ramp) adc_data = adc_data + 8'd1;
    endtask

    task push_ramp(input logic [7:0] a0, input int stride);
        for (int i = 0; i < N; i++) exp_q.push_back(a0 + 8'(i * stride));
    endtask

    task wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1 || count !== 5'd16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b count=%0d, required done=1 busy=0 count=16", name, done, busy, count);
        end
    endtask

    task drain(input string name);
        int k;
        logic [7:0] e, last;
        k = 0;
        last = 8'h00;
        rd_en = 1'b1;
        while (exp_q.size() > 0) begin
            step();
            k++;
            e = exp_q.pop_front();
            last = e;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e || count !== 5'(N - k)) begin
                errors++;
                $display("FAIL %s_pop%0d: valid=%b data=%h count=%0d, required valid=1 data=%h count=%0d",
                         name, k, rd_valid, rd_data, count, e, N - k);
            end
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || done !== 1'b0 || rd_data !== last) begin
            errors++;
            $display("FAIL %s_empty: valid=%b count=%0d done=%b data=%h, required valid=0 count=0 done=0 data=%h",
                     name, rd_valid, count, done, rd_data, last);
        end
    endtask

    task test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL reset: data=%h valid=%b busy=%b done=%b count=%0d, required all zero",
                     rd_data, rd_valid, busy, done, count);
        end
        reset = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL idle_read: valid=%b count=%0d, required valid=0 count=0", rd_valid, count);
        end
    endtask

    task test_immediate();
        trig_mode = 2'b00;
        decim = 8'd0;
        adc_data = 8'h00;
        ramp = 1'b1;
        arm = 1'b1;
        push_ramp(adc_data, 1);
        step();
        arm = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL imm_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done("imm");
        drain("imm");
    endtask

    task test_rise();
        ramp = 1'b0;
        trig_mode = 2'b01;
        trig_level = 8'h80;
        adc_data = 8'h90;
        repeat (3) step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (10) step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rise_steady: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        adc_data = 8'h70;
        step();
        adc_data = 8'h7F;
        step();
        adc_data = 8'h80;
        exp_q.push_back(8'h80);
        step();
        adc_data = 8'h90;
        for (int i = 0; i < N - 1; i++) exp_q.push_back(8'h90 + 8'(i));
        ramp = 1'b1;
        wait_done("rise");
        drain("rise");
    endtask

    task test_fall();
        ramp = 1'b0;
        trig_mode = 2'b10;
        trig_level = 8'h80;
        adc_data = 8'h70;
        repeat (3) step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL fall_steady: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        adc_data = 8'h90;
        step();
        adc_data = 8'h85;
        step();
        adc_data = 8'h7F;
        exp_q.push_back(8'h7F);
        step();
        adc_data = 8'h40;
        for (int i = 0; i < N - 1; i++) exp_q.push_back(8'h40 + 8'(i));
        ramp = 1'b1;
        wait_done("fall");
        drain("fall");
    endtask

    task test_ext();
        trig_mode = 2'b11;
        ext_trig = 1'b0;
        ramp = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (6) step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ext_wait: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        push_ramp(adc_data - 8'd1, 1);
        ext_trig = 1'b1;
        step();
        ext_trig = 1'b0;
        wait_done("ext");
        drain("ext");
    endtask

    task test_decim();
        trig_mode = 2'b00;
        decim = 8'd2;
        ramp = 1'b1;
        arm = 1'b1;
        push_ramp(adc_data, 3);
        step();
        arm = 1'b0;
        wait_done("decim");
        drain("decim");
        decim = 8'd0;
    endtask

    task test_rearm();
        logic [7:0] e;
        trig_mode = 2'b00;
        ramp = 1'b1;
        arm = 1'b1;
        push_ramp(adc_data, 1);
        step();
        arm = 1'b0;
        step();
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        wait_done("rearm_cap");
        rd_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL rearm_pop%0d: valid=%b data=%h, required valid=1 data=%h", k, rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (count !== 5'd9 || rd_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL rearm_count9: count=%0d valid=%b done=%b, required count=9 valid=0 done=1", count, rd_valid, done);
        end
        exp_q.delete();
        arm = 1'b1;
        rd_en = 1'b1;
        push_ramp(adc_data, 1);
        step();
        arm = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || busy !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rearm_done: count=%0d busy=%b done=%b valid=%b, required count=0 busy=1 done=0 valid=0",
                     count, busy, done, rd_valid);
        end
        wait_done("rearm_new");
        drain("rearm_new");
    endtask

    task test_reset_mid();
        trig_mode = 2'b00;
        ramp = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 5'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b count=%0d valid=%b, required all zero", busy, done, count, rd_valid);
        end
        step();
        arm = 1'b1;
        push_ramp(adc_data, 1);
        step();
        arm = 1'b0;
        wait_done("reset_fresh");
        drain("reset_fresh");
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_rise();
        test_fall();
        test_ext();
        test_decim();
        test_rearm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
